// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared constants, command codes and state encoding for the modular multiplier
package mmul_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 16;

  typedef logic [2:0] cmd_op_t;

  localparam cmd_op_t CMD_NOP    = 3'd0;
  localparam cmd_op_t CMD_LOAD   = 3'd1;
  localparam cmd_op_t CMD_UNLOAD = 3'd2;
  localparam cmd_op_t CMD_ROTW   = 3'd3;
  localparam cmd_op_t CMD_SHL1   = 3'd4;
  localparam cmd_op_t CMD_SHR1   = 3'd5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_UNLOAD = 2'd2;

  // A single-word operand still needs a 1-bit counter so the terminal compare exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmul_word_cnt.sv
// rtl/mmul_word_cnt.sv - word up-counter with clear, enable and terminal-count flag
module mmul_word_cnt
  import mmul_pkg::*;
#(
  parameter int N  = NWORDS_DEF,
  parameter int CW = cnt_width(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc  = (r_cnt == CW'(N - 1));
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  // Wrap happens only through the terminal compare, never by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmul_opreg.sv
// rtl/mmul_opreg.sv - word-serial operand register with load/unload, rotate and 1-bit shifts
module mmul_opreg
  import mmul_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_cmd_valid,
  input  logic [2:0]        i_cmd_op,
  output logic              o_cmd_ready,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  output logic [WORD_W-1:0] o_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_ext,
  output logic              o_busy,
  output logic              o_done
);

  localparam int OPW = NWORDS * WORD_W;
  localparam int CW  = cnt_width(NWORDS);

  state_t          r_state;
  logic [OPW-1:0]  r_reg;
  logic            r_ext;
  logic            r_done;

  logic [OPW-1:0]  w_rot;
  logic [OPW-1:0]  w_shift_in;
  logic [CW-1:0]   w_cnt;
  logic            w_tc;
  logic            w_cmd_acc;
  logic            w_load_beat;
  logic            w_unload_beat;
  logic            w_cnt_clr;

  assign w_cmd_acc     = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_load_beat   = (r_state == ST_LOAD) && i_din_valid;
  assign w_unload_beat = (r_state == ST_UNLOAD) && i_dout_ready;
  assign w_cnt_clr     = i_clr ||
                         (w_cmd_acc && ((i_cmd_op == CMD_LOAD) || (i_cmd_op == CMD_UNLOAD)));

  // New words enter at the top, so the first word loaded ends up least significant.
  generate
    if (NWORDS == 1) begin : g_one_word
      assign w_rot      = r_reg;
      assign w_shift_in = i_din;
    end else begin : g_multi_word
      assign w_rot      = {r_reg[WORD_W-1:0], r_reg[OPW-1:WORD_W]};
      assign w_shift_in = {i_din, r_reg[OPW-1:WORD_W]};
    end
  endgenerate

  mmul_word_cnt #(
    .N  (NWORDS),
    .CW (CW)
  ) u_word_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_en    (w_load_beat || w_unload_beat),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_ext   <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      r_reg   <= '0;
      r_ext   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            case (i_cmd_op)
              CMD_LOAD:   r_state <= ST_LOAD;
              CMD_UNLOAD: r_state <= ST_UNLOAD;
              CMD_ROTW:   r_reg   <= w_rot;
              CMD_SHL1:   {r_ext, r_reg} <= {r_reg, 1'b0};
              CMD_SHR1: begin
                r_reg <= {r_ext, r_reg[OPW-1:1]};
                r_ext <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (i_din_valid) begin
            r_reg <= w_shift_in;
            if (w_cnt == '0) begin
              r_ext <= 1'b0;
            end
            if (w_tc) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_UNLOAD: begin
          // A full lap of rotations leaves the operand exactly as it was.
          if (i_dout_ready) begin
            r_reg <= w_rot;
            if (w_tc) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_din_ready  = (r_state == ST_LOAD);
  assign o_dout_valid = (r_state == ST_UNLOAD);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_dout       = r_reg[WORD_W-1:0];
  assign o_ext        = r_ext;

endmodule

// File: tb/tb_mmul_opreg.sv
// tb/tb_mmul_opreg.sv - self-checking bench for mmul_opreg
module tb_mmul_opreg;
  import mmul_pkg::*;

  localparam int W = 16;
  localparam int N = 16;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_clr;
  logic          i_cmd_valid;
  logic [2:0]    i_cmd_op;
  logic          o_cmd_ready;
  logic [W-1:0]  i_din;
  logic          i_din_valid;
  logic          o_din_ready;
  logic [W-1:0]  o_dout;
  logic          o_dout_valid;
  logic          i_dout_ready;
  logic          o_ext;
  logic          o_busy;
  logic          o_done;

  mmul_opreg #(.WORD_W(W), .NWORDS(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clr        (i_clr),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_op     (i_cmd_op),
    .o_cmd_ready  (o_cmd_ready),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .o_din_ready  (o_din_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_ext        (o_ext),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_cycle  = 0;

  // Reference: the operand as an array of words (index 0 least significant) plus ext.
  logic [W-1:0] m_w [N];
  logic         m_ext;
  int           m_mode;  // 0 idle, 1 loading, 2 unloading
  int           m_cnt;
  logic         m_done;

  logic [W-1:0] ld [N];
  logic [W-1:0] beats [$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] dout;
    logic         ext;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] m_value();
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < N; i++) v = v | ((N*W)'(m_w[i]) << (W * i));
    return v;
  endfunction

  task automatic m_set_value(input logic [N*W-1:0] v);
    for (int i = 0; i < N; i++) m_w[i] = W'(v >> (W * i));
  endtask

  task automatic m_rotate();
    logic [W-1:0] t [N];
    for (int i = 0; i < N; i++) t[i] = m_w[i];
    for (int i = 0; i < N; i++) m_w[i] = t[(i + 1) % N];
  endtask

  task automatic model_step(input logic clr, input logic cv, input logic [2:0] op,
                            input logic dv, input logic [W-1:0] d, input logic dr);
    logic [N*W:0] big;
    if (clr) begin
      for (int i = 0; i < N; i++) m_w[i] = '0;
      m_ext = 0; m_mode = 0; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_mode == 0 && cv) begin
      if (op == CMD_LOAD) begin m_mode = 1; m_cnt = 0; end
      else if (op == CMD_UNLOAD) begin m_mode = 2; m_cnt = 0; end
      else if (op == CMD_ROTW) m_rotate();
      else if (op == CMD_SHL1) begin
        big = {1'b0, m_value()} * 2;
        m_ext = big[N*W];
        m_set_value(big[N*W-1:0]);
      end else if (op == CMD_SHR1) begin
        big = {m_ext, m_value()} / 2;
        m_ext = 0;
        m_set_value(big[N*W-1:0]);
      end
    end else if (m_mode == 1 && dv) begin
      if (m_cnt == 0) m_ext = 0;
      for (int i = 0; i < N - 1; i++) m_w[i] = m_w[i+1];
      m_w[N-1] = d;
      m_cnt++;
      if (m_cnt == N) begin m_mode = 0; m_done = 1; end
    end else if (m_mode == 2 && dr) begin
      m_rotate();
      m_cnt++;
      if (m_cnt == N) begin m_mode = 0; m_done = 1; end
    end
  endtask

  task automatic cycle(input logic clr, input logic cv, input logic [2:0] op,
                       input logic dv, input logic [W-1:0] d, input logic dr);
    logic [21:0] exp_v;
    logic [21:0] act_v;
    i_clr = clr; i_cmd_valid = cv; i_cmd_op = op;
    i_din_valid = dv; i_din = d; i_dout_ready = dr;
    if (dr && o_dout_valid) beats.push_back(o_dout);
    model_step(clr, cv, op, dv, d, dr);
    @(posedge i_clk);
    #1;
    n_cycle++;
    if (o_done) n_done++;
    exp_v = {m_mode == 0, m_mode == 1, m_mode == 2, m_mode != 0, m_done, m_ext, m_w[0]};
    act_v = {o_cmd_ready, o_din_ready, o_dout_valid, o_busy, o_done, o_ext, o_dout};
    chk($sformatf("cycle%0d_outputs", n_cycle), 32'(act_v), 32'(exp_v));
  endtask

  task automatic do_load();
    cycle(0, 1, CMD_LOAD, 0, '0, 0);
    for (int i = 0; i < N; i++) cycle(0, 0, CMD_NOP, 1, ld[i], 0);
  endtask

  // pattern 0: always ready; pattern 1: ready 1,0,0,1 repeating
  task automatic do_unload(input int pattern);
    logic dr;
    beats.delete();
    cycle(0, 1, CMD_UNLOAD, 0, '0, 0);
    for (int k = 0; k < 200 && m_mode == 2; k++) begin
      dr = (pattern == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      cycle(0, 0, CMD_NOP, 0, '0, dr);
    end
    chk("unload_finished", 32'(m_mode), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < N; i++) m_w[i] = '0;
    m_ext = 0; m_mode = 0; m_cnt = 0; m_done = 0;
    i_rst_n = 0; i_clr = 0; i_cmd_valid = 0; i_cmd_op = CMD_NOP;
    i_din = '0; i_din_valid = 0; i_dout_ready = 0;

    // Reset values
    #12;
    chk("reset_outputs",
        32'({o_cmd_ready, o_din_ready, o_dout_valid, o_busy, o_done, o_ext, o_dout}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    #5 i_rst_n = 1;

    // Load 1..16, unload with continuous ready
    for (int i = 0; i < N; i++) ld[i] = W'(i + 1);
    d0 = n_done;
    do_load();
    chk("load_done_count", 32'(n_done - d0), 32'd1);
    chk("load_done_with_cmd_ready", 32'({o_done, o_cmd_ready}), 32'b11);
    do_unload(0);
    chk("unload_done_count", 32'(n_done - d0), 32'd2);
    chk("unload_beat_count", 32'(beats.size()), 32'd16);
    for (int i = 0; i < beats.size() && i < N; i++)
      chk($sformatf("unload_beat%0d", i), 32'(beats[i]), 32'(i + 1));

    // Back-to-back single-cycle ops from value 1..16
    tbl[0] = '{CMD_ROTW, 16'h0002, 1'b0};
    tbl[1] = '{CMD_ROTW, 16'h0003, 1'b0};
    tbl[2] = '{CMD_ROTW, 16'h0004, 1'b0};
    tbl[3] = '{CMD_NOP,  16'h0004, 1'b0};
    tbl[4] = '{3'd6,     16'h0004, 1'b0};
    tbl[5] = '{3'd7,     16'h0004, 1'b0};
    tbl[6] = '{CMD_SHR1, 16'h8002, 1'b0};
    tbl[7] = '{CMD_SHL1, 16'h0004, 1'b0};
    tbl[8] = '{CMD_SHL1, 16'h0008, 1'b0};
    tbl[9] = '{CMD_SHR1, 16'h0004, 1'b0};
    for (int k = 0; k < 13; k++)
      tbl[10+k] = '{CMD_ROTW, (k < 12) ? W'(5 + k) : 16'h0001, 1'b0};
    for (int i = 0; i < 23; i++) begin
      cycle(0, 1, tbl[i].op, 0, '0, 0);
      chk($sformatf("tbl%0d_dout_ext", i), 32'({o_ext, o_dout}), 32'({tbl[i].ext, tbl[i].dout}));
    end

    // SHL1 / SHR1 through ext on 0x8000_0000...0001
    for (int i = 0; i < N; i++) ld[i] = '0;
    ld[0] = 16'h0001; ld[N-1] = 16'h8000;
    do_load();
    cycle(0, 1, CMD_SHL1, 0, '0, 0);
    chk("shl1_ext_dout", 32'({o_ext, o_dout}), 32'({1'b1, 16'h0002}));
    cycle(0, 1, CMD_SHR1, 0, '0, 0);
    chk("shr1_ext_dout", 32'({o_ext, o_dout}), 32'({1'b0, 16'h0001}));
    do_unload(0);
    for (int i = 0; i < beats.size() && i < N; i++)
      chk($sformatf("shr1_restore_word%0d", i), 32'(beats[i]), 32'(ld[i]));

    // Unload with ready toggling 1,0,0,1
    for (int i = 0; i < N; i++) ld[i] = W'(i + 1);
    do_load();
    d0 = n_done;
    do_unload(1);
    chk("toggle_beat_count", 32'(beats.size()), 32'd16);
    chk("toggle_done_count", 32'(n_done - d0), 32'd1);
    for (int i = 0; i < beats.size() && i < N; i++)
      chk($sformatf("toggle_beat%0d", i), 32'(beats[i]), 32'(i + 1));

    // clr after 5 load beats, overriding a beat in the same cycle
    d0 = n_done;
    cycle(0, 1, CMD_LOAD, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, CMD_NOP, 1, 16'hA5A0 + W'(i), 0);
    cycle(1, 1, CMD_SHL1, 1, 16'hFFFF, 1);
    chk("clr_state", 32'({o_cmd_ready, o_busy, o_done, o_ext, o_dout}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    cycle(0, 0, CMD_NOP, 0, '0, 0);
    cycle(0, 0, CMD_NOP, 0, '0, 0);
    chk("clr_no_done", 32'(n_done - d0), 32'd0);
    do_unload(0);
    for (int i = 0; i < beats.size() && i < N; i++)
      chk($sformatf("clr_word%0d", i), 32'(beats[i]), 32'd0);

    // SHL1 held during LOAD: blocked until the done cycle, then accepted
    for (int i = 0; i < N; i++) ld[i] = W'(16'h0100 + i);
    cycle(0, 1, CMD_LOAD, 0, '0, 0);
    for (int i = 0; i < N; i++) begin
      cycle(0, 1, CMD_SHL1, 1, ld[i], 0);
      if (i < N - 1) chk($sformatf("busy_cmd_blocked%0d", i), 32'(o_cmd_ready), 32'd0);
    end
    chk("busy_done_ready", 32'({o_done, o_cmd_ready, o_dout}), 32'({1'b1, 1'b1, 16'h0100}));
    cycle(0, 1, CMD_SHL1, 0, '0, 0);
    chk("busy_cmd_after_done", 32'({o_ext, o_dout}), 32'({1'b0, 16'h0200}));

    // Randomised traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      logic [2:0] op;
      int r;
      r  = $urandom_range(0, 9);
      op = (r < 2) ? CMD_LOAD : (r < 4) ? CMD_UNLOAD : 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 1), op,
            $urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
